twiddle_stage_scheduler: RTL and testbench

TWIDDLE_STAGE_SCHEDULER -- requirements
Module: twiddle_stage_scheduler

---
 rtl/twiddle_stage_scheduler.sv | 138 +++++++++++++
 tb/tb_twiddle_stage_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/twiddle_stage_scheduler.sv
// Walks the FFT stages and coefficient blocks that feed a twiddle_factor_generator, with a drain gap between stages.
// Optional build macro TWIDDLE_SCHED_ABORT_EN adds an abort input that cancels a run.
module twiddle_stage_scheduler #(
  parameter int N        = 17,
  parameter int D        = 8,
  parameter int BLOCKS   = 4,
  parameter int PIPE_LAT = 2,
  localparam int S       = $clog2(D),
  localparam int SW      = $clog2(S),
  localparam int BW      = (BLOCKS > 1) ? $clog2(BLOCKS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          inv_req,
`ifdef TWIDDLE_SCHED_ABORT_EN
  input  logic          abort,
`endif
  output logic [SW-1:0] stage,
  output logic          inv,
  output logic [BW-1:0] blk_idx,
  output logic          issue_valid,
  input  logic          issue_ready,
  output logic          busy,
  output logic          done,
  output logic [1:0]    state_dbg
);

  localparam int CW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  if (D < 4 || (D & (D - 1)) != 0 || PIPE_LAT < 1 || BLOCKS < 1 || N < 1) begin : g_bad_params
    $error("twiddle_stage_scheduler: illegal parameter set");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic          inv_q, inv_d;
  logic [BW-1:0] blk_q, blk_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          abort_w;
  logic          last_stage;

`ifdef TWIDDLE_SCHED_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // Inverse runs walk the stages downwards, so the final stage is 0.
  assign last_stage = inv_q ? (stage_q == '0) : (stage_q == SW'(S - 1));

  // Handshake: a beat transfers on a rising edge where issue_valid and
  // issue_ready are both high; while issue_valid is high and issue_ready is
  // low, stage, blk_idx and inv hold, with no timeout.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    inv_d   = inv_q;
    blk_d   = blk_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          inv_d   = inv_req;
          stage_d = inv_req ? SW'(S - 1) : '0;
          blk_d   = '0;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (abort_w) begin
          state_d = IDLE;
        end else if (issue_ready) begin
          if (blk_q == BW'(BLOCKS - 1)) begin
            blk_d   = '0;
            cnt_d   = '0;
            state_d = DRAIN;
          end else begin
            blk_d = blk_q + BW'(1);
          end
        end
      end
      DRAIN: begin
        if (abort_w) begin
          state_d = IDLE;
        end else if (cnt_q == CW'(PIPE_LAT - 1)) begin
          if (last_stage) begin
            state_d = DONE;
          end else begin
            stage_d = inv_q ? (stage_q - SW'(1)) : (stage_q + SW'(1));
            state_d = ISSUE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      inv_q   <= 1'b0;
      blk_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      inv_q   <= inv_d;
      blk_q   <= blk_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stage       = stage_q;
  assign inv         = inv_q;
  assign blk_idx     = blk_q;
  assign issue_valid = (state_q == ISSUE);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_twiddle_stage_scheduler.sv
// Directed bench for twiddle_stage_scheduler at D=8, BLOCKS=4, PIPE_LAT=2 (S=3).
// Table of runs plus hand-written reset, held-start and abort sequences.
module tb_twiddle_stage_scheduler;

  localparam int D        = 8;
  localparam int BLOCKS   = 4;
  localparam int PIPE_LAT = 2;
  localparam int S        = 3;
  localparam int SW       = 2;
  localparam int BW       = 2;

  typedef struct {
    logic inv;
    int   stall_stage;
    int   stall_blk;
    int   stall_len;
    int   done_cycle;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          inv_req = 1'b0;
  logic          issue_ready = 1'b0;
`ifdef TWIDDLE_SCHED_ABORT_EN
  logic          abort = 1'b0;
`endif
  logic [SW-1:0] stage;
  logic          inv;
  logic [BW-1:0] blk_idx;
  logic          issue_valid;
  logic          busy;
  logic          done;
  logic [1:0]    state_dbg;

  vec_t vecs[5];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  twiddle_stage_scheduler #(
    .N(17), .D(D), .BLOCKS(BLOCKS), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .inv_req(inv_req),
`ifdef TWIDDLE_SCHED_ABORT_EN
    .abort(abort),
`endif
    .stage(stage),
    .inv(inv),
    .blk_idx(blk_idx),
    .issue_valid(issue_valid),
    .issue_ready(issue_ready),
    .busy(busy),
    .done(done),
    .state_dbg(state_dbg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_stage"}, 32'(stage), 0);
    check({tag, "_inv"}, 32'(inv), 0);
    check({tag, "_blk"}, 32'(blk_idx), 0);
    check({tag, "_valid"}, 32'(issue_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  // Drives one run with issue_ready high except for an optional stall window;
  // cycle 1 is the cycle right after the start edge.
  task automatic run_vec(input vec_t v, input int tag);
    int beats;
    int c;
    int stall_left;
    int exp_stage;
    bit stalled;
    bit done_seen;
    @(negedge clk);
    start = 1'b1; inv_req = v.inv; issue_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; inv_req = ~v.inv;
    beats = 0; stall_left = 0; stalled = 1'b0; done_seen = 1'b0; c = 1;
    while (!done_seen && c <= 60) begin
      check($sformatf("v%0d_c%0d_inv", tag, c), 32'(inv), 32'(v.inv));
      check($sformatf("v%0d_c%0d_busy", tag, c), 32'(busy), 1);
      if (done) begin
        check($sformatf("v%0d_done_cycle", tag), c, v.done_cycle);
        check($sformatf("v%0d_beats", tag), beats, S * BLOCKS);
        done_seen = 1'b1;
      end else if (issue_valid) begin
        exp_stage = v.inv ? (S - 1 - beats / BLOCKS) : (beats / BLOCKS);
        check($sformatf("v%0d_c%0d_stage", tag, c), 32'(stage), exp_stage);
        check($sformatf("v%0d_c%0d_blk", tag, c), 32'(blk_idx), beats % BLOCKS);
        if (!stalled && v.stall_len > 0 && exp_stage == v.stall_stage &&
            (beats % BLOCKS) == v.stall_blk) begin
          stalled = 1'b1;
          stall_left = v.stall_len;
        end
        if (stall_left > 0) begin
          issue_ready = 1'b0;
          stall_left--;
        end else begin
          issue_ready = 1'b1;
          beats++;
        end
      end else begin
        issue_ready = 1'b1;
      end
      if (!done_seen) begin
        @(negedge clk);
        c++;
      end
    end
    if (!done_seen) check($sformatf("v%0d_done_timeout", tag), 0, 1);
    issue_ready = 1'b1;
    @(negedge clk);
    check($sformatf("v%0d_after_busy", tag), 32'(busy), 0);
    check($sformatf("v%0d_after_done", tag), 32'(done), 0);
    check($sformatf("v%0d_after_valid", tag), 32'(issue_valid), 0);
  endtask

  initial begin
    bit found;
    int n_done;
    int done_at;

    vecs[0] = '{1'b0, 0, 0, 0, 19};
    vecs[1] = '{1'b1, 0, 0, 0, 19};
    vecs[2] = '{1'b0, 1, 2, 5, 24};
    vecs[3] = '{1'b1, 0, 3, 2, 21};
    vecs[4] = '{1'b0, 0, 0, 1, 20};

    #12;
    check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Reset asserted asynchronously during the drain after stage 1.
    @(negedge clk);
    start = 1'b1; inv_req = 1'b0; issue_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (busy && !issue_valid && !done && stage == 2'd1) found = 1'b1;
      else @(negedge clk);
    end
    check("drain1_reached", 32'(found), 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("mid_rst");
    @(negedge clk);
    check_reset_vals("mid_rst_hold");
    rst_n = 1'b1;
    run_vec(vecs[0], 10);

    // start held high through a run; inv_req wiggled mid-run.
    @(negedge clk);
    start = 1'b1; inv_req = 1'b0; issue_ready = 1'b1;
    n_done = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        check("held_done_cycle", c, 19);
      end
      check($sformatf("held_c%0d_inv", c), 32'(inv), 0);
      if (c == 20) check("held_idle_gap_busy", 32'(busy), 0);
      inv_req = (c < 10);
    end
    check("held_done_count", n_done, 1);
    @(negedge clk);
    check("held_rerun_valid", 32'(issue_valid), 1);
    check("held_rerun_stage", 32'(stage), 0);
    check("held_rerun_blk", 32'(blk_idx), 0);
    start = 1'b0;
    done_at = 0;
    for (int c = 22; c <= 45 && done_at == 0; c++) begin
      @(negedge clk);
      if (done) done_at = c;
    end
    check("held_rerun_done_cycle", done_at, 39);
    @(negedge clk);
    check("held_rerun_idle", 32'(busy), 0);

`ifdef TWIDDLE_SCHED_ABORT_EN
    // Abort lands on the same edge as an accepted beat.
    @(negedge clk);
    start = 1'b1; inv_req = 1'b0; issue_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("abort_pre_valid", 32'(issue_valid), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 32'(busy), 0);
    check("abort_valid", 32'(issue_valid), 0);
    check("abort_done", 32'(done), 0);
    n_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    run_vec(vecs[1], 20);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
